// File: rtl/bram_tdp_pkg.sv
// Shared types and constants for the byte-lane true-dual-port block RAM.
package bram_tdp_pkg;

  // Sequencer states: hold in reset, zero-fill sweep, normal operation.
  typedef enum logic [1:0] {
    StRst,
    StInit,
    StReady
  } state_e;

  // Same-port read-during-write behaviour.
  localparam int unsigned RdwOld = 0;
  localparam int unsigned RdwNew = 1;

endpackage

// File: rtl/bram_tdp_port.sv
// Per-port read pipeline: optional same-port write merge, stage-1 register
// and optional output register. Read data holds when no read completes.
module bram_tdp_port
  import bram_tdp_pkg::*;
#(
  parameter int unsigned DWIDTH     = 36,
  parameter int unsigned LANE_WIDTH = 9,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OREG       = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rd_en_i,
  input  logic [DWIDTH-1:0]            mem_rdata_i,
  input  logic                         wr_hit_i,
  input  logic [DWIDTH-1:0]            wd_i,
  input  logic [DWIDTH/LANE_WIDTH-1:0] wbe_i,
  output logic [DWIDTH-1:0]            rq_o
);

  localparam int unsigned NumLanes = DWIDTH / LANE_WIDTH;

  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] s1_data_q, s1_data_d;

  // Same-port write to the read address: overlay the enabled lanes when new-data mode.
  always_comb begin
    rd_word = mem_rdata_i;
    if (RDW_MODE == RdwNew && wr_hit_i) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (wbe_i[l]) begin
          rd_word[l*LANE_WIDTH +: LANE_WIDTH] = wd_i[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Stage 1 captures a read and otherwise holds its last value.
  always_comb begin
    s1_data_d = rd_en_i ? rd_word : s1_data_q;
  end

  // Stage-1 data register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_data_q <= '0;
    end else begin
      s1_data_q <= s1_data_d;
    end
  end

  if (OREG == 1) begin : g_oreg
    logic              s1_vld_q, s1_vld_d;
    logic [DWIDTH-1:0] out_q, out_d;

    // Output stage loads whenever stage 1 carries fresh read data.
    always_comb begin
      s1_vld_d = rd_en_i;
      out_d    = s1_vld_q ? s1_data_q : out_q;
    end

    // Output register and stage-1 valid flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_vld_q <= 1'b0;
        out_q    <= '0;
      end else begin
        s1_vld_q <= s1_vld_d;
        out_q    <= out_d;
      end
    end

    assign rq_o = out_q;
  end else begin : g_no_oreg
    assign rq_o = s1_data_q;
  end

endmodule

// File: rtl/bram_tdp_be.sv
// True-dual-port RAM with per-lane write enables, post-reset zero-fill sweep,
// port-A write priority and a cross-port collision flag.
module bram_tdp_be
  import bram_tdp_pkg::*;
#(
  parameter int unsigned AWIDTH     = 10,
  parameter int unsigned DWIDTH     = 36,
  parameter int unsigned LANE_WIDTH = 9,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OREG       = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         init_busy,
  output logic                         coll,
  input  logic                         rce_a,
  input  logic [AWIDTH-1:0]            ra_a,
  output logic [DWIDTH-1:0]            rq_a,
  input  logic                         wce_a,
  input  logic [AWIDTH-1:0]            wa_a,
  input  logic [DWIDTH-1:0]            wd_a,
  input  logic [DWIDTH/LANE_WIDTH-1:0] wbe_a,
  input  logic                         rce_b,
  input  logic [AWIDTH-1:0]            ra_b,
  output logic [DWIDTH-1:0]            rq_b,
  input  logic                         wce_b,
  input  logic [AWIDTH-1:0]            wa_b,
  input  logic [DWIDTH-1:0]            wd_b,
  input  logic [DWIDTH/LANE_WIDTH-1:0] wbe_b
);

  localparam int unsigned NumLanes = DWIDTH / LANE_WIDTH;
  localparam int unsigned Depth    = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] LastAddr = '1;

  if (DWIDTH % LANE_WIDTH != 0) begin : g_bad_lane
    $error("DWIDTH must be a whole multiple of LANE_WIDTH");
  end
  if (OREG > 1) begin : g_bad_oreg
    $error("OREG must be 0 or 1");
  end
  if (RDW_MODE > 1) begin : g_bad_rdw
    $error("RDW_MODE must be 0 or 1");
  end
  if (INIT_CLEAR > 1) begin : g_bad_init
    $error("INIT_CLEAR must be 0 or 1");
  end

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] init_addr_q, init_addr_d;
  logic              init_busy_q, init_busy_d;
  logic              coll_q, coll_d;

  logic              ready, init_we;
  logic              wr_a, wr_b;
  logic [DWIDTH-1:0] mask_a, mask_b;
  logic [DWIDTH-1:0] word_a, word_b, base_a;
  logic [DWIDTH-1:0] mem [Depth];

  assign ready   = (state_q == StReady);
  assign init_we = (state_q == StInit);
  // An all-zero lane mask is a no-op and does not count as a write.
  assign wr_a    = ready && wce_a && (|wbe_a);
  assign wr_b    = ready && wce_b && (|wbe_b);

  for (genvar l = 0; l < NumLanes; l++) begin : g_mask
    assign mask_a[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wbe_a[l]}};
    assign mask_b[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wbe_b[l]}};
  end

  // Sequencer next state: RST -> INIT sweep (or straight to READY) -> READY.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_busy_d = init_busy_q;
    unique case (state_q)
      StRst: begin
        if (INIT_CLEAR == 1) begin
          state_d     = StInit;
          init_addr_d = '0;
        end else begin
          state_d     = StReady;
          init_busy_d = 1'b0;
        end
      end
      StInit: begin
        // Counter parks on the last address instead of wrapping.
        if (init_addr_q == LastAddr) begin
          state_d     = StReady;
          init_busy_d = 1'b0;
        end else begin
          init_addr_d = init_addr_q + AWIDTH'(1);
        end
      end
      StReady: state_d = StReady;
      default: state_d = StRst;
    endcase
  end

  // Collision: both ports write one address, or one reads what the other writes.
  always_comb begin
    coll_d = ready && ((wr_a && wr_b && (wa_a == wa_b)) ||
                       (rce_a && wr_b && (ra_a == wa_b)) ||
                       (rce_b && wr_a && (ra_b == wa_a)));
  end

  // Sequencer and flag registers; reset restarts any sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRst;
      init_addr_q <= '0;
      init_busy_q <= (INIT_CLEAR == 1);
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_busy_q <= init_busy_d;
      coll_q      <= coll_d;
    end
  end

  // Lane-merged write words; A's word is built on top of B's when addresses match
  // so A owns its enabled lanes and B fills the rest.
  always_comb begin
    word_b = (mem[wa_b] & ~mask_b) | (wd_b & mask_b);
    base_a = (wr_b && (wa_a == wa_b)) ? word_b : mem[wa_a];
    word_a = (base_a & ~mask_a) | (wd_a & mask_a);
  end

  // Storage array; deliberately not reset, the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr_q] <= '0;
    end else begin
      if (wr_b) mem[wa_b] <= word_b;
      if (wr_a) mem[wa_a] <= word_a;
    end
  end

  bram_tdp_port #(
    .DWIDTH     (DWIDTH),
    .LANE_WIDTH (LANE_WIDTH),
    .RDW_MODE   (RDW_MODE),
    .OREG       (OREG)
  ) u_port_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_en_i     (ready && rce_a),
    .mem_rdata_i (mem[ra_a]),
    .wr_hit_i    (ready && wce_a && (wa_a == ra_a)),
    .wd_i        (wd_a),
    .wbe_i       (wbe_a),
    .rq_o        (rq_a)
  );

  bram_tdp_port #(
    .DWIDTH     (DWIDTH),
    .LANE_WIDTH (LANE_WIDTH),
    .RDW_MODE   (RDW_MODE),
    .OREG       (OREG)
  ) u_port_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_en_i     (ready && rce_b),
    .mem_rdata_i (mem[ra_b]),
    .wr_hit_i    (ready && wce_b && (wa_b == ra_b)),
    .wd_i        (wd_b),
    .wbe_i       (wbe_b),
    .rq_o        (rq_b)
  );

  assign init_busy = init_busy_q;
  assign coll      = coll_q;

endmodule

// File: tb/tb_bram_tdp_be.sv
// Bench for bram_tdp_be: two instances on shared stimulus (OREG=0/new-data and
// OREG=1/old-data), a memory model feeding a per-output expected-data queue.
module tb_bram_tdp_be;

  localparam int AW    = 4;
  localparam int DW    = 36;
  localparam int NL    = 4;
  localparam int LW    = 9;
  localparam int DEPTH = 16;
  localparam int NVEC  = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic          rce_a, rce_b, wce_a, wce_b;
  logic [AW-1:0] ra_a, ra_b, wa_a, wa_b;
  logic [DW-1:0] wd_a, wd_b;
  logic [NL-1:0] wbe_a, wbe_b;
  logic [DW-1:0] rq_a0, rq_b0, rq_a1, rq_b1;
  logic          busy0, busy1, coll0, coll1;

  always #5 clk = ~clk;

  bram_tdp_be #(
    .AWIDTH(AW), .DWIDTH(DW), .LANE_WIDTH(LW), .RDW_MODE(1), .OREG(0), .INIT_CLEAR(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy0), .coll(coll0),
    .rce_a(rce_a), .ra_a(ra_a), .rq_a(rq_a0), .wce_a(wce_a), .wa_a(wa_a), .wd_a(wd_a),
    .wbe_a(wbe_a), .rce_b(rce_b), .ra_b(ra_b), .rq_b(rq_b0), .wce_b(wce_b), .wa_b(wa_b),
    .wd_b(wd_b), .wbe_b(wbe_b)
  );

  bram_tdp_be #(
    .AWIDTH(AW), .DWIDTH(DW), .LANE_WIDTH(LW), .RDW_MODE(0), .OREG(1), .INIT_CLEAR(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy1), .coll(coll1),
    .rce_a(rce_a), .ra_a(ra_a), .rq_a(rq_a1), .wce_a(wce_a), .wa_a(wa_a), .wd_a(wd_a),
    .wbe_a(wbe_a), .rce_b(rce_b), .ra_b(ra_b), .rq_b(rq_b1), .wce_b(wce_b), .wa_b(wa_b),
    .wd_b(wd_b), .wbe_b(wbe_b)
  );

  typedef struct {
    logic          rce_a;
    logic [AW-1:0] ra_a;
    logic          wce_a;
    logic [AW-1:0] wa_a;
    logic [DW-1:0] wd_a;
    logic [NL-1:0] wbe_a;
    logic          rce_b;
    logic [AW-1:0] ra_b;
    logic          wce_b;
    logic [AW-1:0] wa_b;
    logic [DW-1:0] wd_b;
    logic [NL-1:0] wbe_b;
    logic          coll;
  } vec_t;

  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } exp_t;

  // Queue index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B.
  exp_t          sbq [4][$];
  logic [DW-1:0] exp_rq [4];
  logic [DW-1:0] model [DEPTH];
  logic          exp_coll, coll_next;
  int            edge_n, rel_edge;
  bit            in_reset;
  int            errors, checks;
  vec_t          vecs [NVEC];

  function automatic vec_t mk(int ra_en, int ra, int wa_en, int wa, logic [DW-1:0] wd,
                              logic [NL-1:0] wbe, int rb_en, int rb, int wb_en, int wb,
                              logic [DW-1:0] wdb, logic [NL-1:0] wbeb, int c);
    vec_t v;
    v.rce_a = (ra_en != 0); v.ra_a = AW'(ra); v.wce_a = (wa_en != 0); v.wa_a = AW'(wa);
    v.wd_a  = wd;           v.wbe_a = wbe;
    v.rce_b = (rb_en != 0); v.ra_b = AW'(rb); v.wce_b = (wb_en != 0); v.wa_b = AW'(wb);
    v.wd_b  = wdb;          v.wbe_b = wbeb;
    v.coll  = (c != 0);
    return v;
  endfunction

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d,
                                          logic [NL-1:0] be);
    logic [DW-1:0] w;
    w = old;
    for (int l = 0; l < NL; l++) if (be[l]) w[l*LW +: LW] = d[l*LW +: LW];
    return w;
  endfunction

  function automatic bit exp_busy();
    return in_reset || (rel_edge < 17);
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic check_outputs();
    chk("rq_a dut0", rq_a0, exp_rq[0]);
    chk("rq_b dut0", rq_b0, exp_rq[1]);
    chk("rq_a dut1", rq_a1, exp_rq[2]);
    chk("rq_b dut1", rq_b1, exp_rq[3]);
    chk("coll dut0", DW'(coll0), DW'(exp_coll));
    chk("coll dut1", DW'(coll1), DW'(exp_coll));
    chk("init_busy dut0", DW'(busy0), DW'(exp_busy()));
    chk("init_busy dut1", DW'(busy1), DW'(exp_busy()));
  endtask

  // Drive one cycle of stimulus; the model only acts when the DUT is READY.
  task automatic apply(input vec_t v);
    logic [DW-1:0] old;
    exp_t e;
    rce_a = v.rce_a; ra_a = v.ra_a; wce_a = v.wce_a; wa_a = v.wa_a; wd_a = v.wd_a;
    wbe_a = v.wbe_a;
    rce_b = v.rce_b; ra_b = v.ra_b; wce_b = v.wce_b; wa_b = v.wa_b; wd_b = v.wd_b;
    wbe_b = v.wbe_b;
    if (!exp_busy()) begin
      if (v.rce_a) begin
        old   = model[v.ra_a];
        e.due = edge_n + 1;
        e.val = (v.wce_a && v.wa_a == v.ra_a) ? merge(old, v.wd_a, v.wbe_a) : old;
        sbq[0].push_back(e);
        e.due = edge_n + 2; e.val = old;
        sbq[2].push_back(e);
      end
      if (v.rce_b) begin
        old   = model[v.ra_b];
        e.due = edge_n + 1;
        e.val = (v.wce_b && v.wa_b == v.ra_b) ? merge(old, v.wd_b, v.wbe_b) : old;
        sbq[1].push_back(e);
        e.due = edge_n + 2; e.val = old;
        sbq[3].push_back(e);
      end
      if (v.wce_b) model[v.wa_b] = merge(model[v.wa_b], v.wd_b, v.wbe_b);
      if (v.wce_a) model[v.wa_a] = merge(model[v.wa_a], v.wd_a, v.wbe_a);
    end
    coll_next = v.coll;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, '0, '0, 0, 0, 0, 0, '0, '0, 0));
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    edge_n++;
    if (!in_reset) begin
      rel_edge++;
      if (rel_edge == 17) for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end
    exp_coll  = coll_next;
    coll_next = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      if (sbq[p].size() > 0 && sbq[p][0].due == edge_n) begin
        e = sbq[p].pop_front();
        exp_rq[p] = e.val;
      end
    end
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_reset = 1'b1;
    rel_edge = 0;
    for (int p = 0; p < 4; p++) begin
      sbq[p].delete();
      exp_rq[p] = '0;
    end
    exp_coll  = 1'b0;
    coll_next = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic release_reset();
    rst_n    = 1'b1;
    in_reset = 1'b0;
    rel_edge = 0;
  endtask

  // Count busy cycles from reset release; optionally try a write mid-sweep.
  task automatic run_init(input string nm, input bit poke);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      if (poke && n == 12) apply(mk(0, 0, 1, 0, 36'hFFFFFFFFF, 4'hF, 0, 0, 0, 0, '0, '0, 0));
      else idle();
      n++;
      step();
    end
    chk(nm, DW'(n), DW'(17));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      apply(mk(1, i, 0, 0, '0, '0, 1, DEPTH - 1 - i, 0, 0, '0, '0, 0));
      step();
    end
    repeat (3) begin idle(); step(); end
  endtask

  initial begin
    errors = 0; checks = 0; edge_n = 0; rel_edge = 0; in_reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    vecs[0]  = mk(0, 0, 1, 3, 36'h123456789, 4'b0101, 0, 0, 0, 0, '0, '0, 0);
    vecs[1]  = mk(0, 0, 0, 0, '0, '0, 1, 3, 0, 0, '0, '0, 0);
    vecs[2]  = mk(0, 0, 1, 5, 36'h111, 4'hF, 0, 0, 0, 0, '0, '0, 0);
    vecs[3]  = mk(1, 5, 1, 5, 36'hAAA, 4'hF, 0, 0, 0, 0, '0, '0, 0);
    vecs[4]  = mk(1, 5, 0, 0, '0, '0, 0, 0, 0, 0, '0, '0, 0);
    vecs[5]  = mk(0, 0, 1, 7, 36'h5A5A5A5A5, 4'b0011, 0, 0, 1, 7, 36'hC3C3C3C3C, 4'hF, 1);
    vecs[6]  = mk(1, 7, 0, 0, '0, '0, 1, 7, 0, 0, '0, '0, 0);
    vecs[7]  = mk(1, 4, 0, 0, '0, '0, 0, 0, 1, 4, 36'h0F0F0F0F0, 4'hF, 1);
    vecs[8]  = mk(1, 3, 0, 0, '0, '0, 1, 4, 0, 0, '0, '0, 0);
    vecs[9]  = mk(0, 0, 1, 9, 36'h123, 4'b0000, 1, 10, 0, 0, '0, '0, 0);
    vecs[10] = mk(1, 9, 0, 0, '0, '0, 0, 0, 0, 0, '0, '0, 0);
    vecs[11] = mk(0, 0, 0, 0, '0, '0, 0, 0, 1, 6, 36'h123456789, 4'hF, 0);
    vecs[12] = mk(0, 0, 0, 0, '0, '0, 1, 6, 1, 6, 36'hABCDE1234, 4'b0110, 0);
    vecs[13] = mk(0, 0, 0, 0, '0, '0, 1, 6, 0, 0, '0, '0, 0);
    vecs[14] = mk(0, 0, 1, 1, 36'h111111111, 4'hF, 0, 0, 1, 2, 36'h222222222, 4'hF, 0);
    vecs[15] = mk(1, 1, 0, 0, '0, '0, 0, 0, 0, 0, '0, '0, 0);
    vecs[16] = mk(1, 2, 0, 0, '0, '0, 0, 0, 0, 0, '0, '0, 0);
    vecs[17] = mk(1, 3, 0, 0, '0, '0, 0, 0, 0, 0, '0, '0, 0);

    idle();
    #2;
    do_reset();
    step();
    release_reset();
    run_init("init busy length", 1'b1);
    read_all();

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      step();
    end
    repeat (3) begin idle(); step(); end

    // Reset from READY with non-zero read data, then again mid-sweep at address 9.
    apply(mk(1, 7, 0, 0, '0, '0, 1, 4, 0, 0, '0, '0, 0));
    step();
    idle();
    step();
    do_reset();
    step();
    release_reset();
    repeat (10) begin idle(); step(); end
    do_reset();
    step();
    release_reset();
    run_init("restarted init length", 1'b0);
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
